muldiv_unit: RTL and testbench



---
 rtl/muldiv_types.sv | 31 +++
 rtl/cond_negate.sv | 13 +
 rtl/muldiv_unit.sv | 177 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_types.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// Contents: operation encoding, FSM state encoding, width and special-result constants.
package muldiv_types;

  localparam int unsigned MULDIV_N  = 32;
  localparam int unsigned MULDIV_CW = $clog2(MULDIV_N);

  // Quotient returned for a divide by zero.
  localparam logic [MULDIV_N-1:0] MULDIV_DIV0_Q = {MULDIV_N{1'b1}};
  // Most negative signed value; dividend of the signed-overflow case.
  localparam logic [MULDIV_N-1:0] MULDIV_MIN_NEG = {1'b1, {(MULDIV_N-1){1'b0}}};

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } muldiv_state_t;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negate.
// Ports: negate - invert sign when high; value - W-bit input; result_c - combinational W-bit output.
module cond_negate #(
  parameter int unsigned W = 32
) (
  input  logic         negate,
  input  logic [W-1:0] value,
  output logic [W-1:0] result_c
);

  assign result_c = negate ? (~value + W'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle shift-add multiply and
// restoring shift-subtract divide, with valid/ready handshakes on request and result.
// Optional build macro: MULDIV_EARLY_OUT_EN - trivial cases (divide by zero, signed
// overflow, multiply by zero) go straight from IDLE to DONE.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_valid / o_ready   request handshake; i_op, i_a, i_b captured at accept
//   o_valid / i_ready   result handshake; o_result held while o_valid is high
//   o_busy              high in every state except IDLE
module muldiv_unit
  import muldiv_types::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [2:0]          i_op,
  input  logic [MULDIV_N-1:0] i_a,
  input  logic [MULDIV_N-1:0] i_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [MULDIV_N-1:0] o_result,
  output logic                o_busy
);

  localparam int unsigned N  = MULDIV_N;
  localparam int unsigned CW = MULDIV_CW;

  muldiv_state_t     state;
  muldiv_op_t        op_q;
  logic [CW-1:0]     cnt;
  // Multiply: running product. Divide: remainder in the upper half, dividend/quotient in the lower.
  logic [2*N-1:0]    prod;
  // Multiply: |a| (the addend). Divide: |b| (the divisor).
  logic [N-1:0]      addend_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              spec_q;
  logic [N-1:0]      res_q;

  // Request decode and operand absolute values.
  logic              is_mul_c;
  logic              a_signed_c;
  logic              b_signed_c;
  logic              a_neg_c;
  logic              b_neg_c;
  logic [N-1:0]      a_abs_c;
  logic [N-1:0]      b_abs_c;
  logic              ovf_c;
  logic              spec_c;
  logic [N-1:0]      spec_val_c;

  always_comb begin
    is_mul_c   = ~i_op[2];
    a_signed_c = (i_op == OP_MUL) || (i_op == OP_MULH) || (i_op == OP_MULHSU) ||
                 (i_op == OP_DIV) || (i_op == OP_REM);
    b_signed_c = (i_op == OP_MUL) || (i_op == OP_MULH) ||
                 (i_op == OP_DIV) || (i_op == OP_REM);
    a_neg_c    = a_signed_c && i_a[N-1];
    b_neg_c    = b_signed_c && i_b[N-1];
    ovf_c      = ((i_op == OP_DIV) || (i_op == OP_REM)) &&
                 (i_a == MULDIV_MIN_NEG) && (i_b == {N{1'b1}});
    spec_c     = is_mul_c ? ((i_a == '0) || (i_b == '0)) : ((i_b == '0) || ovf_c);
    spec_val_c = '0;
    if (!is_mul_c) begin
      if (i_b == '0) spec_val_c = i_op[1] ? i_a : MULDIV_DIV0_Q;
      else if (ovf_c) spec_val_c = i_op[1] ? '0 : MULDIV_MIN_NEG;
    end
  end

  cond_negate #(.W(N)) u_abs_a (.negate(a_neg_c), .value(i_a), .result_c(a_abs_c));
  cond_negate #(.W(N)) u_abs_b (.negate(b_neg_c), .value(i_b), .result_c(b_abs_c));

  // One iteration of each datapath.
  logic [N:0]        mul_sum_c;
  logic [2*N-1:0]    mul_step_c;
  logic [N:0]        rem_shift_c;
  logic [N:0]        div_trial_c;
  logic [2*N-1:0]    div_step_c;

  always_comb begin
    mul_sum_c   = {1'b0, prod[2*N-1:N]} + {1'b0, addend_q};
    mul_step_c  = prod[0] ? {mul_sum_c, prod[N-1:1]} : {1'b0, prod[2*N-1:1]};
    rem_shift_c = {prod[2*N-1:N], prod[N-1]};
    div_trial_c = rem_shift_c - {1'b0, addend_q};
    // Borrow out of the trial subtract means the divisor did not fit: restore.
    if (!div_trial_c[N]) div_step_c = {div_trial_c[N-1:0], prod[N-2:0], 1'b1};
    else                 div_step_c = {rem_shift_c[N-1:0], prod[N-2:0], 1'b0};
  end

  // Sign fix: remainders and quotients are zero-extended into the 2N-bit negator.
  logic              fix_en_c;
  logic [2*N-1:0]    fix_in_c;
  logic [2*N-1:0]    fix_out_c;
  logic [N-1:0]      fix_sel_c;

  always_comb begin
    fix_en_c = neg_res_q;
    fix_in_c = prod;
    if (op_q[2]) begin
      if (op_q[1]) begin
        fix_en_c = neg_rem_q;
        fix_in_c = {{N{1'b0}}, prod[2*N-1:N]};
      end else begin
        fix_in_c = {{N{1'b0}}, prod[N-1:0]};
      end
    end
  end

  cond_negate #(.W(2*N)) u_fix (.negate(fix_en_c), .value(fix_in_c), .result_c(fix_out_c));

  assign fix_sel_c = (op_q[2] || (op_q == OP_MUL)) ? fix_out_c[N-1:0] : fix_out_c[2*N-1:N];

  // Control FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_MUL;
      cnt       <= '0;
      prod      <= '0;
      addend_q  <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      spec_q    <= 1'b0;
      res_q     <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            op_q      <= muldiv_op_t'(i_op);
            cnt       <= CW'(N-1);
            addend_q  <= is_mul_c ? a_abs_c : b_abs_c;
            prod      <= {{N{1'b0}}, (is_mul_c ? b_abs_c : a_abs_c)};
            neg_res_q <= a_neg_c ^ b_neg_c;
            neg_rem_q <= a_neg_c;
            spec_q    <= spec_c;
            res_q     <= spec_val_c;
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
`ifdef MULDIV_EARLY_OUT_EN
            state     <= spec_c ? DONE : CALC;
`else
            state     <= CALC;
`endif
          end
        end
        CALC: begin
          prod <= op_q[2] ? div_step_c : mul_step_c;
          cnt  <= cnt - 1'b1;
          if (cnt == '0) state <= FIX;
        end
        FIX: begin
          // Special cases keep the value chosen at accept so both builds agree.
          if (!spec_q) res_q <= fix_sel_c;
          state <= DONE;
        end
        DONE: begin
          if (!o_valid) begin
            o_valid  <= 1'b1;
            o_result <= res_q;
          end else if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import muldiv_types::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int SPEC_LAT = 1;
`else
  localparam int SPEC_LAT = 34;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_op;
  logic [31:0] i_a;
  logic [31:0] i_b;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_busy;

  int compared   = 0;
  int mismatched = 0;

  muldiv_unit dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_op(i_op),
    .i_a(i_a), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
    .o_result(o_result), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  // Issue one op, wait (bounded) for the result, then hand it off.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int busy_low);
    i_op = op; i_a = a; i_b = b; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_a = $urandom; i_b = $urandom; i_op = ~op;
    lat = 0; busy_low = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (!o_busy) busy_low++;
    end while (!o_valid && lat < 100);
    compared++;
    if (!o_valid) begin
      mismatched++;
      $display("FAIL timeout: o_valid=%0b after %0d cycles, required 1", o_valid, lat);
    end
    res = o_result;
    i_ready = 1'b1;
    @(posedge clk); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b0; i_op = '0; i_a = '0; i_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    compared++;
    if ({o_ready, o_valid, o_busy, o_result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      mismatched++;
      $display("FAIL reset_state: rdy/vld/busy/res=%b/%b/%b/%h required 1/0/0/00000000",
               o_ready, o_valid, o_busy, o_result);
    end
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat; int bl;
    run_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, r, lat, bl);
    compared++;
    if (r !== 32'hFFFF_FFEB) begin mismatched++; $display("FAIL mul_7x-3: got %h required ffffffeb", r); end
    compared++;
    if (lat !== 34) begin mismatched++; $display("FAIL mul_latency: got %0d required 34", lat); end
    compared++;
    if (bl !== 0) begin mismatched++; $display("FAIL mul_busy: busy low %0d cycles required 0", bl); end
    run_op(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bl);
    compared++;
    if (r !== 32'hFFFF_FFFE) begin mismatched++; $display("FAIL mulhu_max: got %h required fffffffe", r); end
    run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, bl);
    compared++;
    if (r !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL mulhsu: got %h required ffffffff", r); end
    run_op(OP_MULH, 32'hFFFF_FFFE, 32'd3, r, lat, bl);
    compared++;
    if (r !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL mulh_-2x3: got %h required ffffffff", r); end
    run_op(OP_MUL, 32'd0, 32'd12345, r, lat, bl);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL mul_zero: got %h required 00000000", r); end
    compared++;
    if (lat !== SPEC_LAT) begin mismatched++; $display("FAIL mul_zero_latency: got %0d required %0d", lat, SPEC_LAT); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat; int bl;
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, r, lat, bl);
    compared++;
    if (r !== 32'hFFFF_FFFD) begin mismatched++; $display("FAIL div_-7/2: got %h required fffffffd", r); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd2, r, lat, bl);
    compared++;
    if (r !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL rem_-7/2: got %h required ffffffff", r); end
    run_op(OP_DIVU, 32'd100, 32'd7, r, lat, bl);
    compared++;
    if (r !== 32'd14) begin mismatched++; $display("FAIL divu_100/7: got %h required 0000000e", r); end
    run_op(OP_REMU, 32'd100, 32'd7, r, lat, bl);
    compared++;
    if (r !== 32'd2) begin mismatched++; $display("FAIL remu_100/7: got %h required 00000002", r); end
  endtask

  task automatic test_div_special();
    logic [31:0] r; int lat; int bl;
    run_op(OP_DIVU, 32'h8000_0000, 32'd0, r, lat, bl);
    compared++;
    if (r !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL divu_by0: got %h required ffffffff", r); end
    compared++;
    if (lat !== SPEC_LAT) begin mismatched++; $display("FAIL div0_latency: got %0d required %0d", lat, SPEC_LAT); end
    run_op(OP_REMU, 32'h8000_0000, 32'd0, r, lat, bl);
    compared++;
    if (r !== 32'h8000_0000) begin mismatched++; $display("FAIL remu_by0: got %h required 80000000", r); end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0, r, lat, bl);
    compared++;
    if (r !== 32'hFFFF_FFFF) begin mismatched++; $display("FAIL div_neg_by0: got %h required ffffffff", r); end
    run_op(OP_REM, 32'hFFFF_FFF9, 32'd0, r, lat, bl);
    compared++;
    if (r !== 32'hFFFF_FFF9) begin mismatched++; $display("FAIL rem_neg_by0: got %h required fffffff9", r); end
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bl);
    compared++;
    if (r !== 32'h8000_0000) begin mismatched++; $display("FAIL div_ovf: got %h required 80000000", r); end
    compared++;
    if (lat !== SPEC_LAT) begin mismatched++; $display("FAIL ovf_latency: got %0d required %0d", lat, SPEC_LAT); end
    run_op(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, bl);
    compared++;
    if (r !== 32'h0) begin mismatched++; $display("FAIL rem_ovf: got %h required 00000000", r); end
  endtask

  task automatic test_hold_and_handoff();
    logic [31:0] r; int lat; int bl;
    i_op = OP_MUL; i_a = 32'd1000; i_b = 32'd1000; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    lat = 0;
    while (!o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    for (int i = 0; i < 5; i++) begin
      compared++;
      if (o_valid !== 1'b1 || o_result !== 32'd1000000) begin
        mismatched++;
        $display("FAIL hold_cycle%0d: vld=%b res=%h required 1/000f4240", i, o_valid, o_result);
      end
      @(posedge clk); #1;
    end
    // Handoff cycle with a new request already present: it must wait one cycle.
    i_ready = 1'b1; i_valid = 1'b1; i_op = OP_MULHU; i_a = 32'h0001_0000; i_b = 32'h0003_0000;
    @(posedge clk); #1;
    i_ready = 1'b0;
    compared++;
    if ({o_valid, o_ready, o_busy} !== 3'b010) begin
      mismatched++;
      $display("FAIL handoff_no_accept: vld/rdy/busy=%b required 010", {o_valid, o_ready, o_busy});
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    compared++;
    if ({o_ready, o_busy} !== 2'b01) begin
      mismatched++;
      $display("FAIL accept_next: rdy/busy=%b required 01", {o_ready, o_busy});
    end
    lat = 0;
    while (!o_valid && lat < 100) begin @(posedge clk); #1; lat++; end
    compared++;
    if (o_result !== 32'd3) begin mismatched++; $display("FAIL late_accept_result: got %h required 00000003", o_result); end
    i_ready = 1'b1; @(posedge clk); #1; i_ready = 1'b0;
    // i_ready held high throughout: ignored until the result appears.
    i_ready = 1'b1;
    run_op(OP_MULHU, 32'h0001_0000, 32'h0001_0000, r, lat, bl);
    compared++;
    if (r !== 32'd1 || lat !== 34) begin
      mismatched++;
      $display("FAIL early_ready: res=%h lat=%0d required 00000001/34", r, lat);
    end
  endtask

  task automatic test_reset_midop();
    logic [31:0] r; int lat; int bl;
    i_op = OP_MUL; i_a = 32'd99; i_b = 32'd77; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    compared++;
    if ({o_ready, o_valid, o_busy, o_result} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      mismatched++;
      $display("FAIL reset_midcalc: rdy/vld/busy/res=%b/%b/%b/%h required 1/0/0/00000000",
               o_ready, o_valid, o_busy, o_result);
    end
    // Reset beats a simultaneous request.
    rst = 1'b1; i_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_valid = 1'b0;
    compared++;
    if ({o_ready, o_busy} !== 2'b10) begin
      mismatched++;
      $display("FAIL reset_vs_valid: rdy/busy=%b required 10", {o_ready, o_busy});
    end
    run_op(OP_MUL, 32'd3, 32'd4, r, lat, bl);
    compared++;
    if (r !== 32'd12) begin mismatched++; $display("FAIL mul_after_reset: got %h required 0000000c", r); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_special();
    test_hold_and_handoff();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
